// File: rtl/instr_fetch_if.sv
// Instruction-memory request channel between the IF stage and instruction memory.
// The master (IF stage) drives the request and address; the slave (memory)
// returns the instruction word and its valid strobe.
interface instr_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemValid;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemRdata,
    input  imemValid
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemRdata,
    output imemValid
  );
endinterface

// File: rtl/instr_fetch.sv
// IF stage of the pipelined MIPS. Holds the PC, fetches over a req/valid
// handshake and fills the IF/ID register (ifbus = {instruction, pcPlus4}).
// Redirects (branch / jr) from decode, decode stalls and memory wait states
// are handled by a 3-state FSM:
//   S_REQ  : request outstanding at PC
//   S_HOLD : data returned while decode stalled, word parked in a hold buffer
//   S_DROP : redirect arrived mid-request; wait for the stale word, discard it
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          pcSrcId,
  input  logic [31:0]         pcBranchId,
  input  logic [31:0]         jumpAddress,
  input  logic                stallD,
  instr_fetch_if.master       imem,
  output logic [63:0]         ifbus,
  output logic [31:0]         fetchCount,
  output logic [31:0]         bubbleCount
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [63:0] BUBBLE = {NOP_INSTR, 32'h0000_0000};

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [63:0] r_ifbus, w_ifbus_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic [31:0] r_drop_target, w_drop_target_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_load_instr;
  logic        w_load_bubble;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = pcSrcId[1] ? jumpAddress : pcBranchId;
  assign w_redirect = (pcSrcId != 2'b00) && !stallD;

  // Memory-side outputs: request dropped while parked in S_HOLD or in reset.
  always_comb begin
    imem.imemReq  = !reset && (r_state != S_HOLD);
    imem.imemAddr = r_pc;
  end

  assign ifbus = r_ifbus;

  // Next-state, PC and IF/ID selection in the documented priority order.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ifbus_nxt       = r_ifbus;
    w_hold_nxt        = r_hold;
    w_drop_target_nxt = r_drop_target;
    w_load_instr      = 1'b0;
    w_load_bubble     = 1'b0;

    unique case (r_state)
      S_REQ: begin
        if (w_redirect && imem.imemValid) begin
          w_pc_nxt      = w_target;
          w_ifbus_nxt   = BUBBLE;
          w_load_bubble = 1'b1;
        end else if (w_redirect) begin
          w_drop_target_nxt = w_target;
          w_ifbus_nxt       = BUBBLE;
          w_load_bubble     = 1'b1;
          w_state_nxt       = S_DROP;
        end else if (imem.imemValid && !stallD) begin
          w_ifbus_nxt  = {imem.imemRdata, w_pc_plus4};
          w_pc_nxt     = w_pc_plus4;
          w_load_instr = 1'b1;
        end else if (imem.imemValid) begin
          w_hold_nxt  = imem.imemRdata;
          w_state_nxt = S_HOLD;
        end else if (!stallD) begin
          w_ifbus_nxt   = BUBBLE;
          w_load_bubble = 1'b1;
        end
      end

      S_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt      = w_target;
          w_ifbus_nxt   = BUBBLE;
          w_load_bubble = 1'b1;
          w_state_nxt   = S_REQ;
        end else if (!stallD) begin
          w_ifbus_nxt  = {r_hold, w_pc_plus4};
          w_pc_nxt     = w_pc_plus4;
          w_load_instr = 1'b1;
          w_state_nxt  = S_REQ;
        end
      end

      S_DROP: begin
        // PC must stay at the stale address until its word returns.
        if (imem.imemValid) begin
          w_pc_nxt    = r_drop_target;
          w_state_nxt = S_REQ;
        end
        if (!stallD) begin
          w_ifbus_nxt   = BUBBLE;
          w_load_bubble = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // State, PC, IF/ID, hold buffer and drop target registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_ifbus       <= '0;
      r_hold        <= '0;
      r_drop_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ifbus       <= w_ifbus_nxt;
      r_hold        <= w_hold_nxt;
      r_drop_target <= w_drop_target_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  // Count real instructions and bubbles written into IF/ID.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_load_instr)  r_fetch_count  <= r_fetch_count + 32'd1;
      if (w_load_bubble) r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign fetchCount  = r_fetch_count;
  assign bubbleCount = r_bubble_count;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_load_instr ^ w_load_bubble;
  assign fetchCount    = '0;
  assign bubbleCount   = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. Two instances (RESET_PC = 0 and
// RESET_PC = 32'hFFFF_FFFC) share one stimulus stream; each has its own
// behavioural reference model. Memory word at address a is (a >> 2) + 0x100.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pcSrcId;
  logic [31:0] pcBranchId;
  logic [31:0] jumpAddress;
  logic        stallD;
  logic        valid;

  logic [63:0] ifbus0, ifbus1;
  logic [31:0] fc0, fc1, bc0, bc1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [31:0] RST_PC [2] = '{32'h0000_0000, 32'hFFFF_FFFC};

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  instr_fetch_if bus0 ();
  instr_fetch_if bus1 ();

  assign bus0.imemRdata = memf(bus0.imemAddr);
  assign bus1.imemRdata = memf(bus1.imemAddr);
  assign bus0.imemValid = valid;
  assign bus1.imemValid = valid;

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset), .pcSrcId(pcSrcId), .pcBranchId(pcBranchId),
    .jumpAddress(jumpAddress), .stallD(stallD), .imem(bus0), .ifbus(ifbus0),
    .fetchCount(fc0), .bubbleCount(bc0)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut1 (
    .clock(clock), .reset(reset), .pcSrcId(pcSrcId), .pcBranchId(pcBranchId),
    .jumpAddress(jumpAddress), .stallD(stallD), .imem(bus1), .ifbus(ifbus1),
    .fetchCount(fc1), .bubbleCount(bc1)
  );

  // Reference model state: PC, parked word, pending-discard flag and target.
  logic [31:0] m_pc     [2];
  bit          m_hfull  [2];
  logic [31:0] m_hold   [2];
  bit          m_drop   [2];
  logic [31:0] m_dtgt   [2];
  logic [63:0] m_ifbus  [2];
  logic [31:0] m_fc     [2];
  logic [31:0] m_bc     [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge of the fetch stage, described by its externally visible rules.
  task automatic model_step(input int k, input logic rst, input logic [1:0] src,
                            input logic [31:0] br, input logic [31:0] jmp,
                            input logic st, input logic v);
    logic [31:0] tgt;
    bit redir;
    if (rst) begin
      m_pc[k] = RST_PC[k]; m_hfull[k] = 0; m_hold[k] = 0; m_drop[k] = 0;
      m_dtgt[k] = 0; m_ifbus[k] = 0; m_fc[k] = 0; m_bc[k] = 0;
      return;
    end
    tgt   = src[1] ? jmp : br;
    redir = (src != 2'b00) && !st;
    if (m_drop[k]) begin
      if (v) begin m_pc[k] = m_dtgt[k]; m_drop[k] = 0; end
      if (!st) begin m_ifbus[k] = 64'h0; m_bc[k]++; end
    end else if (m_hfull[k]) begin
      if (redir) begin
        m_pc[k] = tgt; m_hfull[k] = 0; m_ifbus[k] = 64'h0; m_bc[k]++;
      end else if (!st) begin
        m_ifbus[k] = {m_hold[k], m_pc[k] + 32'd4}; m_pc[k] += 32'd4;
        m_hfull[k] = 0; m_fc[k]++;
      end
    end else begin
      if (redir) begin
        m_ifbus[k] = 64'h0; m_bc[k]++;
        if (v) m_pc[k] = tgt;
        else begin m_drop[k] = 1; m_dtgt[k] = tgt; end
      end else if (v && !st) begin
        m_ifbus[k] = {memf(m_pc[k]), m_pc[k] + 32'd4}; m_pc[k] += 32'd4; m_fc[k]++;
      end else if (v) begin
        m_hold[k] = memf(m_pc[k]); m_hfull[k] = 1;
      end else if (!st) begin
        m_ifbus[k] = 64'h0; m_bc[k]++;
      end
    end
  endtask

  task automatic cycle(input logic rst, input logic [1:0] src, input logic [31:0] br,
                       input logic [31:0] jmp, input logic st, input logic v);
    reset = rst; pcSrcId = src; pcBranchId = br; jumpAddress = jmp;
    stallD = st; valid = v;
    #1;
    check_eq("req0", 64'(bus0.imemReq), 64'(!rst && !m_hfull[0]));
    check_eq("req1", 64'(bus1.imemReq), 64'(!rst && !m_hfull[1]));
    if (!rst) begin
      check_eq("addr0", 64'(bus0.imemAddr), 64'(m_pc[0]));
      check_eq("addr1", 64'(bus1.imemAddr), 64'(m_pc[1]));
    end
    for (int k = 0; k < 2; k++) model_step(k, rst, src, br, jmp, st, v);
    @(posedge clock);
    #1;
    check_eq("ifbus0", ifbus0, m_ifbus[0]);
    check_eq("ifbus1", ifbus1, m_ifbus[1]);
`ifdef IF_PERF_CNT_EN
    check_eq("fcnt0", 64'(fc0), 64'(m_fc[0]));
    check_eq("bcnt0", 64'(bc0), 64'(m_bc[0]));
    check_eq("fcnt1", 64'(fc1), 64'(m_fc[1]));
    check_eq("bcnt1", 64'(bc1), 64'(m_bc[1]));
`else
    check_eq("fcnt0", 64'(fc0), 64'h0);
    check_eq("bcnt0", 64'(bc0), 64'h0);
    check_eq("fcnt1", 64'(fc1), 64'h0);
    check_eq("bcnt1", 64'(bc1), 64'h0);
`endif
  endtask

  initial begin
    logic        r_rst, r_st, r_v;
    logic [1:0]  r_src;
    logic [31:0] r_br, r_jmp;

    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_hfull[k] = 0; m_hold[k] = 0; m_drop[k] = 0;
      m_dtgt[k] = 0; m_ifbus[k] = 0; m_fc[k] = 0; m_bc[k] = 0;
    end
    reset = 1'b1; pcSrcId = 2'b00; pcBranchId = '0; jumpAddress = '0;
    stallD = 1'b0; valid = 1'b0;
    @(posedge clock); #1;

    // Reset, then zero-wait sequential fetch.
    cycle(1, 2'b00, 0, 0, 0, 0);
    cycle(1, 2'b00, 0, 0, 0, 1);
    check_eq("rst_ifbus", ifbus0, 64'h0);
    check_eq("rst_addr", 64'(bus0.imemAddr), 64'h0);
    cycle(0, 2'b00, 0, 0, 0, 1);
    check_eq("zw0", ifbus0, {32'h100, 32'h4});
    check_eq("wrap_pc4", 64'(ifbus1[31:0]), 64'h0);
    check_eq("wrap_addr", 64'(bus1.imemAddr), 64'h0);
    cycle(0, 2'b00, 0, 0, 0, 1);
    check_eq("zw1", ifbus0, {32'h101, 32'h8});
    cycle(0, 2'b00, 0, 0, 0, 1);
    check_eq("zw2", ifbus0, {32'h102, 32'hC});

    // Branch redirect with zero-wait memory.
    cycle(0, 2'b01, 32'h80, 0, 0, 1);
    check_eq("br_bubble", ifbus0, 64'h0);
    check_eq("br_addr", 64'(bus0.imemAddr), 64'h80);
    cycle(0, 2'b00, 0, 0, 0, 1);
    check_eq("br_fetch", ifbus0, {32'h120, 32'h84});

    // Decode stall with data returned.
    cycle(0, 2'b00, 0, 0, 1, 1);
    check_eq("hold_req", 64'(bus0.imemReq), 64'h0);
    cycle(0, 2'b00, 0, 0, 1, 1);
    cycle(0, 2'b00, 0, 0, 1, 0);
    check_eq("hold_ifbus", ifbus0, {32'h120, 32'h84});
    cycle(0, 2'b00, 0, 0, 0, 0);
    check_eq("hold_rel", ifbus0, {32'h121, 32'h88});

    // jr arriving during an outstanding request with wait states.
    cycle(0, 2'b00, 0, 0, 0, 0);
    cycle(0, 2'b10, 0, 32'h400, 0, 0);
    check_eq("drop_addr0", 64'(bus0.imemAddr), 64'h88);
    cycle(0, 2'b00, 0, 0, 0, 0);
    check_eq("drop_addr1", 64'(bus0.imemAddr), 64'h88);
    check_eq("drop_bubble", ifbus0, 64'h0);
    cycle(0, 2'b00, 0, 0, 0, 1);
    check_eq("jr_addr", 64'(bus0.imemAddr), 64'h400);

    // Redirect presented while stalled is ignored until the stall drops.
    cycle(0, 2'b01, 32'h200, 0, 1, 1);
    check_eq("stl_br_addr", 64'(bus0.imemAddr), 64'h400);
    cycle(0, 2'b01, 32'h200, 0, 0, 0);
    check_eq("stl_br_taken", 64'(bus0.imemAddr), 64'h200);

    // Reset in the middle of a wait.
    cycle(0, 2'b00, 0, 0, 0, 0);
    cycle(1, 2'b01, 32'h300, 0, 0, 0);
    check_eq("mid_rst_ifbus", ifbus0, 64'h0);
    check_eq("mid_rst_addr", 64'(bus0.imemAddr), 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      r_src = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_br  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023)) & ~32'h3;
      r_jmp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 1023)) & ~32'h3;
      r_st  = ($urandom_range(0, 3) == 0);
      r_v   = ($urandom_range(0, 9) < 6);
      cycle(r_rst, r_src, r_br, r_jmp, r_st, r_v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- IF stage of the pipelined MIPS; upstream end of the IF/ID interface (`ifbus`) consumed by the decode stage.
- Holds the PC and issues requests to instruction memory over a req/valid handshake.
- Registers `{instruction, pc+4}` into the IF/ID pipeline register and applies redirects (branch, `jr`) from decode.
- Handles memory wait states, decode stalls, and flushes with a 3-state FSM.

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000, bubble instruction written to IF/ID on flush or empty cycle (decodes to no regWrite, no memWrite, no branch).

Ports:
- `clock` input 1: rising-edge clock.
- `reset` input 1: reset, synchronous, active-high.
- `pcSrcId` input 2: redirect select from decode. 00 = sequential, 01 = branch, 1x = jump (jump wins).
- `pcBranchId` input 32: branch target from decode.
- `jumpAddress` input 32: `jr` target from decode.
- `stallD` input 1: decode stall (hazard unit); IF/ID must hold.
- `imemReq` output 1: instruction memory request.
- `imemAddr` output 32: fetch address (= current PC).
- `imemRdata` input 32: returned instruction word.
- `imemValid` input 1: `imemRdata` valid; sampled only while `imemReq`=1.
- `ifbus` output 64: IF/ID register; [31:0] = pcPlus4, [63:32] = instruction.
- `fetchCount` output 32: instructions delivered to IF/ID (optional feature).
- `bubbleCount` output 32: NOPs inserted into IF/ID (optional feature).

Behaviour:
- Reset (sync): PC=`RESET_PC`, state=S_REQ, `ifbus`=0, hold buffer=0, drop target=0, counters=0. `imemReq`=0 while `reset`=1; first request in the first cycle after release.
- `imemAddr`=PC at all times. The memory contract requires PC/`imemAddr` to stay stable while `imemReq`=1 until `imemValid`.
- `imemReq`=1 in S_REQ and S_DROP, 0 in S_HOLD.
- Zero-wait memory (`imemValid` in the same cycle as request): one instruction per cycle, latency 1 edge from request to `ifbus`.
- redirect = (`pcSrcId`!=00) && !`stallD`. Target = `jumpAddress` if `pcSrcId`[1], else `pcBranchId`. Redirect is ignored when `stallD`=1 and in S_DROP.
- Bubble = `{NOP_INSTR, 32'h0}`.
- S_REQ, evaluated per edge in priority order:
  - redirect && `imemValid`: discard data; PC<=target; IF/ID<=bubble; stay S_REQ.
  - redirect && !`imemValid`: droptarget<=target; IF/ID<=bubble; go S_DROP.
  - `imemValid` && !`stallD`: IF/ID<={rdata, PC+4}; PC<=PC+4; stay.
  - `imemValid` && `stallD`: hold<=rdata; IF/ID holds; go S_HOLD.
  - !`imemValid` && !`stallD`: IF/ID<=bubble.
  - !`imemValid` && `stallD`: IF/ID holds.
- S_HOLD:
  - redirect: discard hold; PC<=target; IF/ID<=bubble; go S_REQ.
  - !`stallD`: IF/ID<={hold, PC+4}; PC<=PC+4; go S_REQ.
  - else: hold.
- S_DROP:
  - on `imemValid`: discard data; PC<=droptarget; go S_REQ.
  - IF/ID<=bubble whenever !`stallD`.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). Targets are used unaligned as given.
- Redirect during reset: reset wins; all state re-initialised; an in-flight request is abandoned (the memory must accept `imemReq` dropping on reset).

Optional Feature:
- Macro `IF_PERF_CNT_EN`.
- Defined:
  - `fetchCount` +1 on each edge loading a real instruction into IF/ID.
  - `bubbleCount` +1 on each edge loading a bubble.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both outputs tied 0; no counter registers.

Test Plan:
- Zero-wait: reset, `RESET_PC`=0, `imemValid`=1 constantly, mem[i]=i+0x100 -> `ifbus` = {0x100, 4}, {0x101, 8}, {0x102, 12} on consecutive edges; `imemAddr` 0, 4, 8.
- Stall with data returned: `stallD`=1 for 3 cycles while fetching PC=0x20 -> `imemReq`=0 in S_HOLD, `ifbus` unchanged; on release `ifbus`={mem[0x20], 0x24}, next `imemAddr`=0x24.
- Branch redirect: `pcSrcId`=01, `pcBranchId`=0x80 with zero-wait memory -> next `ifbus`={0, 0}, then `imemAddr`=0x80 and `ifbus`={mem[0x80], 0x84}.
- `jr` with 3 wait states: `pcSrcId`=10, `jumpAddress`=0x400 one cycle into an outstanding request at 0x10 -> FSM enters S_DROP, `imemAddr` stays 0x10 until `imemValid`, data discarded, bubbles in IF/ID, then `imemAddr`=0x400.
- Redirect while stalled: `pcSrcId`=01 with `stallD`=1 -> no redirect, PC unchanged; redirect taken on the edge after `stallD` drops.
- Wrap and reset: `RESET_PC`=32'hFFFF_FFFC -> first `ifbus` pcPlus4=0 and next `imemAddr`=0. Assert `reset` mid wait -> `imemReq`=0 during reset, `ifbus`=0, fetch restarts at `RESET_PC`. With `IF_PERF_CNT_EN`, counters read 0 after reset.
